// File: rtl/display_pkg.sv
// display_pkg: digit codes, FSM states and active-low segment decode
package display_pkg;
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:     seg_lut = 7'h40;
            4'd1:     seg_lut = 7'h79;
            4'd2:     seg_lut = 7'h24;
            4'd3:     seg_lut = 7'h30;
            4'd4:     seg_lut = 7'h19;
            4'd5:     seg_lut = 7'h12;
            4'd6:     seg_lut = 7'h02;
            4'd7:     seg_lut = 7'h78;
            4'd8:     seg_lut = 7'h00;
            4'd9:     seg_lut = 7'h10;
            DIG_DASH: seg_lut = 7'h3F;
            default:  seg_lut = 7'h7F;
        endcase
    endfunction
endpackage

// File: rtl/bcd_dabble.sv
// bcd_dabble: serial 14-bit binary to 5-digit BCD, 16 cycles per conversion
module bcd_dabble (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic        done_o,
    output logic [19:0] bcd_o
);
    logic [13:0] bin_q;
    logic [19:0] bcd_q;
    logic [19:0] adj;
    logic [3:0]  step_q;
    logic        run_q;

    for (genvar g = 0; g < 5; g++) begin : g_adj
        assign adj[4*g +: 4] = bcd_q[4*g +: 4] >= 4'd5 ? bcd_q[4*g +: 4] + 4'd3 : bcd_q[4*g +: 4];
    end

    // The start cycle is the load slot; steps 1..14 shift, step 15 is the store slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            step_q <= 4'd0;
            bin_q  <= '0;
            bcd_q  <= '0;
        end else if (!run_q) begin
            if (start_i) begin
                run_q  <= 1'b1;
                step_q <= 4'd1;
                bin_q  <= bin_i;
                bcd_q  <= '0;
            end
        end else if (step_q == 4'd15) begin
            run_q <= 1'b0;
        end else begin
            {bcd_q, bin_q} <= {adj, bin_q} << 1;
            step_q         <= step_q + 4'd1;
        end
    end

    assign done_o = run_q && step_q == 4'd15;
    assign bcd_o  = bcd_q;
endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: snapshots time/date fields, converts them to BCD and
// scans them onto an 8-digit common-anode 7-segment display.
module display_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        refresh,
    input  logic        page,
    input  logic [5:0]  sec_bin,
    input  logic [5:0]  min_bin,
    input  logic [4:0]  hour_bin,
    input  logic [4:0]  day_bin,
    input  logic [3:0]  month_bin,
    input  logic [13:0] year_bin,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic        busy,
    output logic        frame_done
);
    import display_pkg::*;

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GRD  = PW'(GUARD);

    state_t      state_q, state_d;
    logic [5:0]  sec_q, min_q;
    logic [4:0]  hour_q, day_q;
    logic [3:0]  mon_q;
    logic [13:0] year_q;
    logic        page_q;
    logic [2:0]  field_q;
    logic [39:0] two_q;
    logic [19:0] yr_q;
    logic [31:0] disp_q, disp_d;
    logic [7:0]  dpm_q, dpm_d;
    logic [13:0] fbin;
    logic [19:0] bcd;
    logic [15:0] ydig;
    logic        start, done, accept;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (refresh ? CONV : IDLE)
                : state_q == CONV ? (done && field_q == 3'd5 ? COMMIT : CONV)
                : IDLE;
    end

    always_comb begin
        busy       = state_q != IDLE;
        frame_done = state_q == COMMIT;
        start      = state_q == CONV;
        accept     = state_q == IDLE && refresh;
    end

    assign fbin = field_q == 3'd0 ? {8'd0, sec_q}
                : field_q == 3'd1 ? {8'd0, min_q}
                : field_q == 3'd2 ? {9'd0, hour_q}
                : field_q == 3'd3 ? {9'd0, day_q}
                : field_q == 3'd4 ? {10'd0, mon_q}
                : year_q;

    bcd_dabble u_dabble (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (fbin),
        .done_o  (done),
        .bcd_o   (bcd)
    );

    // A fifth nonzero BCD digit means the year cannot be shown in four digits.
    assign ydig   = |yr_q[19:16] ? {4{DIG_DASH}} : yr_q[15:0];
    assign disp_d = page_q ? {two_q[31:24], two_q[39:32], ydig} : {DIG_BLANK, DIG_BLANK, two_q[23:0]};
    assign dpm_d  = page_q ? 8'b0101_0000 : 8'b0001_0100;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sec_q, min_q, hour_q, day_q, mon_q, year_q, page_q} <= '0;
            field_q <= 3'd0;
            two_q   <= '0;
            yr_q    <= '0;
            disp_q  <= {8{DIG_BLANK}};
            dpm_q   <= 8'd0;
        end else begin
            if (accept) begin
                {sec_q, min_q, hour_q, day_q, mon_q, year_q, page_q} <=
                    {sec_bin, min_bin, hour_bin, day_bin, month_bin, year_bin, page};
                field_q <= 3'd0;
            end else if (done) begin
                field_q <= field_q + 3'd1;
            end
            if (done && field_q != 3'd5) two_q[{field_q, 3'b000} +: 8] <= bcd[7:0];
            if (done && field_q == 3'd5) yr_q <= bcd;
            if (frame_done) begin
                disp_q <= disp_d;
                dpm_q  <= dpm_d;
            end
        end
    end

    always_comb begin
        presc_d = presc_q == LAST ? '0 : presc_q + 1'b1;
        idx_d   = presc_q == LAST ? idx_q + 3'd1 : idx_q;
        an_d    = presc_d < GRD ? 8'hFF : ~(8'd1 << idx_d);
        seg_d   = seg_lut(disp_q[{idx_d, 2'b00} +: 4]);
        dp_d    = ~dpm_q[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            an_n    <= 8'hFF;
            seg_n   <= 7'h7F;
            dp_n    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_n    <= an_d;
            seg_n   <= seg_d;
            dp_n    <= dp_d;
        end
    end
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: directed tests of refresh latency, page layout,
// year overflow, busy-drop of refresh, reset abort and scan timing.
module tb_display_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        refresh = 1'b0;
    logic        page = 1'b0;
    logic [5:0]  sec_bin = '0, min_bin = '0;
    logic [4:0]  hour_bin = '0, day_bin = '0;
    logic [3:0]  month_bin = '0;
    logic [13:0] year_bin = '0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic        busy, frame_done;

    int checks = 0;
    int errors = 0;
    int fd_at, nfd;
    logic b1, b98;
    logic [6:0] seg_cap [8];
    logic [7:0] dp_cap;

    display_scan_driver #(.SCAN_DIV(4), .GUARD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .refresh    (refresh),
        .page       (page),
        .sec_bin    (sec_bin),
        .min_bin    (min_bin),
        .hour_bin   (hour_bin),
        .day_bin    (day_bin),
        .month_bin  (month_bin),
        .year_bin   (year_bin),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses refresh after edge 0 and observes cycles 1..110.
    task automatic run_frame();
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        fd_at = -1;
        nfd = 0;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (c == 1) b1 = busy;
            if (c == 98) b98 = busy;
            if (frame_done) begin
                nfd++;
                if (fd_at < 0) fd_at = c;
            end
            tick();
        end
    endtask

    task automatic capture_frame();
        for (int i = 0; i < 8; i++) seg_cap[i] = 'x;
        dp_cap = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++)
                if (an_n == ~(8'd1 << i)) begin
                    seg_cap[i] = seg_n;
                    dp_cap[i]  = dp_n;
                end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_an;
        repeat (3) tick();
        checks++;
        if ({an_n, seg_n, dp_n, busy, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got an=%h seg=%h dp=%b busy=%b fd=%b", an_n, seg_n, dp_n, busy, frame_done);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            exp_an = (k % 4 == 0) ? 8'hFF : ~(8'd1 << ((k / 4) % 8));
            checks++;
            if (an_n !== exp_an || seg_n !== 7'h7F || busy !== 1'b0) begin
                errors++;
                $display("FAIL scan_cycle%0d: got an=%h seg=%h busy=%b expected an=%h seg=7f busy=0", k, an_n, seg_n, busy, exp_an);
            end
            tick();
        end
    endtask

    task automatic check_frame(input string name, input logic [6:0] es [8], input logic [7:0] edp);
        capture_frame();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seg_cap[i] !== es[i]) begin
                errors++;
                $display("FAIL %s_seg%0d: got %h expected %h", name, i, seg_cap[i], es[i]);
            end
        end
        checks++;
        if (dp_cap !== edp) begin
            errors++;
            $display("FAIL %s_dp: got %b expected %b", name, dp_cap, edp);
        end
    endtask

    task automatic test_time();
        logic [6:0] es [8] = '{7'h78, 7'h40, 7'h10, 7'h12, 7'h30, 7'h24, 7'h7F, 7'h7F};
        page = 1'b0; hour_bin = 5'd23; min_bin = 6'd59; sec_bin = 6'd7;
        run_frame();
        checks++;
        if (b1 !== 1'b1 || b98 !== 1'b0) begin
            errors++;
            $display("FAIL time_busy: got c1=%b c98=%b expected c1=1 c98=0", b1, b98);
        end
        checks++;
        if (fd_at !== 97 || nfd !== 1) begin
            errors++;
            $display("FAIL time_frame_done: got cycle %0d count %0d expected cycle 97 count 1", fd_at, nfd);
        end
        check_frame("time", es, 8'b1110_1011);
    endtask

    task automatic test_date();
        logic [6:0] es [8] = '{7'h19, 7'h24, 7'h40, 7'h24, 7'h24, 7'h40, 7'h79, 7'h40};
        page = 1'b1; day_bin = 5'd1; month_bin = 4'd2; year_bin = 14'd2024;
        run_frame();
        checks++;
        if (fd_at !== 97 || nfd !== 1) begin
            errors++;
            $display("FAIL date_frame_done: got cycle %0d count %0d expected cycle 97 count 1", fd_at, nfd);
        end
        check_frame("date", es, 8'b1010_1111);
    endtask

    task automatic test_year_overflow();
        logic [6:0] es [8] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h79, 7'h79, 7'h12, 7'h79};
        page = 1'b1; day_bin = 5'd15; month_bin = 4'd11; year_bin = 14'd12000;
        run_frame();
        check_frame("yovf", es, 8'b1010_1111);
    endtask

    task automatic test_back_to_back();
        logic [6:0] es [8] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F};
        page = 1'b0; hour_bin = 5'd12; min_bin = 6'd34; sec_bin = 6'd56;
        day_bin = 5'd9; month_bin = 4'd9; year_bin = 14'd1999;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        nfd = 0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (frame_done) nfd++;
            tick();
            if (c + 1 == 5) begin
                page = 1'b1; hour_bin = 5'd1; min_bin = 6'd2; sec_bin = 6'd3;
                day_bin = 5'd4; month_bin = 4'd5; year_bin = 14'd6789;
            end
            refresh = (c + 1 == 10);
        end
        checks++;
        if (nfd !== 1) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d frame_done pulses expected 1", nfd);
        end
        check_frame("b2b", es, 8'b1110_1011);
    endtask

    task automatic test_reset_mid_conv();
        logic [6:0] es [8] = '{default: 7'h7F};
        int bad_fd, bad_busy;
        page = 1'b0; hour_bin = 5'd8; min_bin = 6'd8; sec_bin = 6'd8;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        repeat (39) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an_n, seg_n, dp_n, busy, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_outputs: got an=%h seg=%h dp=%b busy=%b fd=%b", an_n, seg_n, dp_n, busy, frame_done);
        end
        tick();
        tick();
        rst_n = 1'b1;
        bad_fd = 0;
        bad_busy = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (frame_done) bad_fd++;
            if (busy) bad_busy++;
            tick();
        end
        checks++;
        if (bad_fd !== 0 || bad_busy !== 0) begin
            errors++;
            $display("FAIL abort_idle: got %0d frame_done and %0d busy cycles expected 0 and 0", bad_fd, bad_busy);
        end
        check_frame("abort", es, 8'hFF);
    endtask

    initial begin
        test_reset();
        test_time();
        test_date();
        test_year_overflow();
        test_back_to_back();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
